// File: rtl/src_b_mux_pkg.sv
// Shared types and constants for the ALU operand-B stage.
// Forwarding/stall support is compiled in only when SRC_B_FWD_EN is defined.
package src_b_mux_pkg;

    typedef enum logic [1:0] {
        SEL_SRC_B_RS2  = 2'd0,
        SEL_SRC_B_IMM  = 2'd1,
        SEL_SRC_B_ZERO = 2'd2,
        SEL_SRC_B_FOUR = 2'd3
    } sel_src_b_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        STALL = 2'd2
    } state_e;

    localparam int unsigned CONST_FOUR = 4;

endpackage

// File: rtl/src_b_fwd_resolve.sv
// Combinational priority match of a register index against the forwarding sources.
// Source 0 is the youngest and wins; x0 never matches.
module src_b_fwd_resolve #(
    parameter int XLEN       = 32,
    parameter int NUM_FWD    = 2,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0]         addr,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
    input  logic [NUM_FWD-1:0]            fwd_pending,
    output logic                          hit,
    output logic                          pending,
    output logic [XLEN-1:0]               data
);

    logic [NUM_FWD-1:0] match;

    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_match
            assign match[gi] = fwd_valid[gi]
                            && (fwd_addr[gi*REG_ADDR_W +: REG_ADDR_W] == addr)
                            && (addr != '0);
        end
    endgenerate

    // Walk from oldest to youngest so the lowest matching index is the last writer.
    always_comb begin
        hit     = 1'b0;
        pending = 1'b0;
        data    = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                pending = fwd_pending[i];
                data    = fwd_data[i*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/src_b_operand_stage.sv
// Registered ALU operand-B stage: selects rs2/imm/0/4 into a valid/ready output register.
// Define SRC_B_FWD_EN to enable rs2 forwarding and the load-use STALL state.
module src_b_operand_stage
    import src_b_mux_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_FWD    = 2,
    parameter int REG_ADDR_W = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [REG_ADDR_W-1:0]         rs2_addr,
    input  logic [XLEN-1:0]               rs2_data,
    input  logic [XLEN-1:0]               imm,
    input  sel_src_b_t                    select,
    input  logic [NUM_FWD-1:0]            fwd_valid,
    input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
    input  logic [NUM_FWD-1:0]            fwd_pending,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               alu_src_b,
    output logic                          stall_o
);

    state_e          state_reg;
    logic            out_valid_reg;
    logic            stall_reg;
    logic [XLEN-1:0] alu_src_b_reg;
    logic            accept;
    logic [XLEN-1:0] rs2_value;
    logic [XLEN-1:0] resolved;

    assign in_ready  = !flush && ((state_reg == EMPTY) || ((state_reg == FULL) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign stall_o   = stall_reg;
    assign alu_src_b = alu_src_b_reg;

`ifdef SRC_B_FWD_EN
    logic [REG_ADDR_W-1:0] held_addr_reg;
    logic [REG_ADDR_W-1:0] lookup_addr;
    logic                  fwd_hit;
    logic                  fwd_pend;
    logic [XLEN-1:0]       fwd_value;
    logic                  hazard;

    // While stalled the decode inputs may have moved on; resolve the latched index.
    assign lookup_addr = (state_reg == STALL) ? held_addr_reg : rs2_addr;

    src_b_fwd_resolve #(
        .XLEN       (XLEN),
        .NUM_FWD    (NUM_FWD),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_resolve (
        .addr        (lookup_addr),
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .fwd_pending (fwd_pending),
        .hit         (fwd_hit),
        .pending     (fwd_pend),
        .data        (fwd_value)
    );

    assign rs2_value = fwd_hit ? fwd_value : rs2_data;
    assign hazard    = (select == SEL_SRC_B_RS2) && fwd_hit && fwd_pend;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_addr, fwd_data, fwd_pending};
    assign rs2_value  = rs2_data;
`endif

    always_comb begin
        resolved = '0;
        case (select)
            SEL_SRC_B_RS2:  resolved = rs2_value;
            SEL_SRC_B_IMM:  resolved = imm;
            SEL_SRC_B_ZERO: resolved = '0;
            SEL_SRC_B_FOUR: resolved = XLEN'(CONST_FOUR);
            default:        resolved = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
            stall_reg     <= 1'b0;
            alu_src_b_reg <= '0;
`ifdef SRC_B_FWD_EN
            held_addr_reg <= '0;
`endif
        end else if (flush) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
            stall_reg     <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY, FULL: begin
                    if (accept) begin
`ifdef SRC_B_FWD_EN
                        if (hazard) begin
                            state_reg     <= STALL;
                            held_addr_reg <= rs2_addr;
                            out_valid_reg <= 1'b0;
                            stall_reg     <= 1'b1;
                        end else
`endif
                        begin
                            alu_src_b_reg <= resolved;
                            state_reg     <= FULL;
                            out_valid_reg <= 1'b1;
                            stall_reg     <= 1'b0;
                        end
                    end else if ((state_reg == FULL) && out_ready) begin
                        state_reg     <= EMPTY;
                        out_valid_reg <= 1'b0;
                    end
                end
`ifdef SRC_B_FWD_EN
                // A vanished match means write-back happened, so rs2_value is rs2_data.
                STALL: begin
                    if (!(fwd_hit && fwd_pend)) begin
                        alu_src_b_reg <= rs2_value;
                        state_reg     <= FULL;
                        out_valid_reg <= 1'b1;
                        stall_reg     <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_reg     <= EMPTY;
                    out_valid_reg <= 1'b0;
                    stall_reg     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_src_b_operand_stage.sv
// Scoreboard bench for src_b_operand_stage: expected operands are queued at accept
// and popped by a monitor on each output handshake. Honours SRC_B_FWD_EN.
module tb_src_b_operand_stage;
    import src_b_mux_pkg::*;

    localparam int XLEN = 32;
    localparam int NUM_FWD = 2;
    localparam int AW = 5;
`ifdef SRC_B_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [AW-1:0] rs2_addr = '0;
    logic [XLEN-1:0] rs2_data = '0;
    logic [XLEN-1:0] imm = '0;
    sel_src_b_t select = SEL_SRC_B_ZERO;
    logic [NUM_FWD-1:0] fwd_valid = '0;
    logic [NUM_FWD*AW-1:0] fwd_addr = '0;
    logic [NUM_FWD*XLEN-1:0] fwd_data = '0;
    logic [NUM_FWD-1:0] fwd_pending = '0;
    logic out_valid;
    logic out_ready;
    logic [XLEN-1:0] alu_src_b;
    logic stall_o;

    logic fixed_ready = 1'b1;
    logic rand_ready = 1'b0;
    logic rnd_ready = 1'b1;
    assign out_ready = rand_ready ? rnd_ready : fixed_ready;

    int n_checks = 0;
    int n_fail = 0;
    logic [XLEN-1:0] exp_q[$];

    src_b_operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data), .imm(imm), .select(select),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .fwd_pending(fwd_pending), .out_valid(out_valid), .out_ready(out_ready),
        .alu_src_b(alu_src_b), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the operand the ALU should see, and whether a load-use stall is due.
    function automatic void model(input sel_src_b_t s, input logic [XLEN-1:0] im,
                                  input logic [AW-1:0] ra, input logic [XLEN-1:0] rd,
                                  input logic [NUM_FWD-1:0] fv, input logic [NUM_FWD*AW-1:0] fa,
                                  input logic [NUM_FWD*XLEN-1:0] fd, input logic [NUM_FWD-1:0] fp,
                                  output logic [XLEN-1:0] v, output bit hz);
        hz = 1'b0;
        case (s)
            SEL_SRC_B_IMM:  v = im;
            SEL_SRC_B_ZERO: v = 0;
            SEL_SRC_B_FOUR: v = 4;
            default: begin
                v = rd;
                if (FWD_EN && ra != 0) begin
                    for (int i = 0; i < NUM_FWD; i++) begin
                        if (fv[i] && fa[i*AW +: AW] == ra) begin
                            v = fd[i*XLEN +: XLEN];
                            hz = fp[i];
                            break;
                        end
                    end
                end
            end
        endcase
    endfunction

    // Monitor: every output handshake consumes the oldest expected operand.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got 0x%08h expected no output", alu_src_b);
            end else begin
                logic [XLEN-1:0] e;
                e = exp_q.pop_front();
                if (alu_src_b !== e) begin
                    n_fail++;
                    $display("FAIL alu_src_b: got 0x%08h expected 0x%08h at %0t", alu_src_b, e, $time);
                end else begin
                    $display("txn ok: alu_src_b=0x%08h at %0t", alu_src_b, $time);
                end
            end
        end
    end

    task automatic send(input sel_src_b_t s, input logic [XLEN-1:0] im, input logic [AW-1:0] ra,
                        input logic [XLEN-1:0] rd, input logic [NUM_FWD-1:0] fv,
                        input logic [NUM_FWD*AW-1:0] fa, input logic [NUM_FWD*XLEN-1:0] fd,
                        input logic [NUM_FWD-1:0] fp, input int hold, output int waited);
        logic [XLEN-1:0] ev;
        bit hz;
        model(s, im, ra, rd, fv, fa, fd, fp, ev, hz);
        @(posedge clk);
        #1;
        select = s; imm = im; rs2_addr = ra; rs2_data = rd;
        fwd_valid = fv; fwd_addr = fa; fwd_data = fd; fwd_pending = fp;
        in_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) break;
        end
        if (waited > 50) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (hz) begin
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk("stall_o_hold", 32'(stall_o), 32'd1);
                chk("out_valid_hold", 32'(out_valid), 32'd0);
                chk("in_ready_hold", 32'(in_ready), 32'd0);
            end
            fwd_pending = '0;
        end
        exp_q.push_back(ev);
        @(negedge clk);
        chk("out_valid_latency", 32'(out_valid), 32'd1);
        chk("stall_o_clear", 32'(stall_o), 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rand_ready = 1'b0;
        fixed_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int w;
        logic [XLEN-1:0] bp_val;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_alu_src_b", alu_src_b, 32'd0);
        chk("reset_stall_o", 32'(stall_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Constant and immediate selections.
        send(SEL_SRC_B_IMM, 32'hDEAD_BEEF, 5'd0, 32'h0, 2'b00, '0, '0, 2'b00, 0, w);
        send(SEL_SRC_B_FOUR, 32'hFFFF_FFFF, 5'd3, 32'h7, 2'b00, '0, '0, 2'b00, 0, w);
        send(SEL_SRC_B_ZERO, 32'h1234_5678, 5'd3, 32'h7, 2'b00, '0, '0, 2'b00, 0, w);
        // Youngest forward wins; x0 never forwards.
        send(SEL_SRC_B_RS2, 32'h0, 5'd5, 32'h11, 2'b11, {5'd5, 5'd5}, {32'h33, 32'h22}, 2'b00, 0, w);
        send(SEL_SRC_B_RS2, 32'h0, 5'd5, 32'h11, 2'b10, {5'd5, 5'd6}, {32'h33, 32'h22}, 2'b00, 0, w);
        send(SEL_SRC_B_RS2, 32'h0, 5'd0, 32'h0, 2'b01, {5'd0, 5'd0}, {32'h0, 32'h99}, 2'b00, 0, w);
        // Load-use: fwd0 pending for 3 cycles.
        send(SEL_SRC_B_RS2, 32'h0, 5'd7, 32'h44, 2'b01, {5'd0, 5'd7}, {32'h0, 32'hCAFE_0007}, 2'b01, 3, w);
        drain();

        // Backpressure then back-to-back refill.
        fixed_ready = 1'b0;
        bp_val = 32'hA5A5_0001;
        send(SEL_SRC_B_IMM, bp_val, 5'd0, 32'h0, 2'b00, '0, '0, 2'b00, 0, w);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_alu_src_b_stable", alu_src_b, bp_val);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        fixed_ready = 1'b1;
        send(SEL_SRC_B_IMM, 32'hA5A5_0002, 5'd0, 32'h0, 2'b00, '0, '0, 2'b00, 0, w);
        chk("b2b_no_wait", 32'(w), 32'd0);
        drain();

        // Flush kills a held operand.
        @(posedge clk);
        #1;
`ifdef SRC_B_FWD_EN
        select = SEL_SRC_B_RS2; rs2_addr = 5'd9; fwd_valid = 2'b01;
        fwd_addr = {5'd0, 5'd9}; fwd_data = {32'h0, 32'h5555}; fwd_pending = 2'b01;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_pre_stall", 32'(stall_o), 32'd1);
`else
        fixed_ready = 1'b0;
        select = SEL_SRC_B_IMM; imm = 32'h0BAD_F00D; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_pre_full", 32'(out_valid), 32'd1);
`endif
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        fwd_pending = '0;
        fwd_valid = '0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_stall_o", 32'(stall_o), 32'd0);
        fixed_ready = 1'b1;
        @(negedge clk);
        chk("flush_no_output", 32'(out_valid), 32'd0);

        // Asynchronous reset while FULL.
        fixed_ready = 1'b0;
        @(posedge clk);
        #1;
        select = SEL_SRC_B_IMM; imm = 32'h1234_5678; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_alu_src_b", alu_src_b, 32'h1234_5678);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 32'(out_valid), 32'd0);
        chk("async_reset_alu_src_b", alu_src_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fixed_ready = 1'b1;

        // Randomized traffic with random output backpressure.
        rand_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            sel_src_b_t s;
            logic [NUM_FWD-1:0] fp;
            s = sel_src_b_t'($urandom_range(0, 3));
            fp[0] = ($urandom_range(0, 3) == 0);
            fp[1] = ($urandom_range(0, 3) == 0);
            send(s, $urandom, 5'($urandom_range(0, 7)), $urandom, 2'($urandom_range(0, 3)),
                 {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))}, {$urandom, $urandom},
                 fp, $urandom_range(1, 3), w);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
